// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI slave front end for the single-port RAM.
// MOSI frames of RX_WIDTH bits become rx_data/rx_valid. RAM read data
// (tx_data/tx_valid) is shifted out on MISO, MSB first, after a read-data frame.
// The SPI bit clock is clk: one bit moves per clk while SS_n is low.
//
// Optional feature, enabled by defining SPI_FRAME_ERR_EN:
//   adds output frame_err. It pulses for one cycle when SS_n rises part-way
//   through a frame or part-way through a MISO readout.
//
// Handshake: rx_valid is a one-cycle strobe with no back-pressure. rx_data
// is valid in that cycle and holds until the next completed frame.
// tx_valid is a one-cycle strobe from the RAM. It is accepted only while a
// READ_DATA frame has completed and its readout has not yet started.
// tx_valid at any other time is ignored.
module spi_slave_if #(
  parameter int RX_WIDTH = 10,
  parameter int TX_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                SS_n,
  input  logic                MOSI,
  output logic                MISO,
  output logic [RX_WIDTH-1:0] rx_data,
  output logic                rx_valid,
  input  logic [TX_WIDTH-1:0] tx_data,
  input  logic                tx_valid,
  output logic [2:0]          state_dbg
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic                frame_err
`endif
);

  localparam int RCW = $clog2(RX_WIDTH + 1);
  localparam int TCW = $clog2(TX_WIDTH + 1);

  // Counts MOSI bits sampled in the current frame. RX_DONE marks a completed frame.
  localparam logic [RCW-1:0] RX_LAST = RCW'(RX_WIDTH - 1);
  localparam logic [RCW-1:0] RX_DONE = RCW'(RX_WIDTH);
  localparam logic [TCW-1:0] TX_FULL = TCW'(TX_WIDTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_e;

  state_e                state_q,        state_d;
  logic [RCW-1:0]        rx_cnt_q,       rx_cnt_d;
  logic [RX_WIDTH-2:0]   rx_shift_q,     rx_shift_d;
  logic [RX_WIDTH-1:0]   rx_data_q,      rx_data_d;
  logic                  rx_valid_q,     rx_valid_d;
  logic                  rd_addr_seen_q, rd_addr_seen_d;
  logic                  tx_wait_q,      tx_wait_d;
  logic [TX_WIDTH-1:0]   tx_shift_q,     tx_shift_d;
  logic [TCW-1:0]        tx_cnt_q,       tx_cnt_d;
  logic                  miso_q,         miso_d;
`ifdef SPI_FRAME_ERR_EN
  logic                  frame_err_q,    frame_err_d;
`endif

  // The frame is unfinished if not all MOSI bits arrived or the MISO readout is still pending.
  logic frame_open;
  assign frame_open = (rx_cnt_q != RX_DONE) || tx_wait_q || (tx_cnt_q != '0);

  // Next-state logic: command decode, MOSI deserialiser and MISO serialiser.
  always_comb begin
    state_d        = state_q;
    rx_cnt_d       = rx_cnt_q;
    rx_shift_d     = rx_shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_seen_d = rd_addr_seen_q;
    tx_wait_d      = tx_wait_q;
    tx_shift_d     = tx_shift_q;
    tx_cnt_d       = tx_cnt_q;
    miso_d         = 1'b0;
`ifdef SPI_FRAME_ERR_EN
    frame_err_d    = 1'b0;
`endif

    if (SS_n) begin
      // Deselect aborts everything. A partial frame leaves rd_addr_seen untouched.
      state_d    = IDLE;
      rx_cnt_d   = '0;
      tx_wait_d  = 1'b0;
      tx_cnt_d   = '0;
      tx_shift_d = '0;
`ifdef SPI_FRAME_ERR_EN
      frame_err_d = (state_q != IDLE) && frame_open;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = CHK_CMD;
          rx_cnt_d = '0;
        end

        CHK_CMD: begin
          // The first MOSI bit is the frame MSB and selects the transaction type.
          rx_shift_d = {rx_shift_q[RX_WIDTH-3:0], MOSI};
          rx_cnt_d   = RCW'(1);
          if (!MOSI) begin
            state_d = WRITE;
          end else if (rd_addr_seen_q) begin
            state_d = READ_DATA;
          end else begin
            state_d = READ_ADD;
          end
        end

        WRITE, READ_ADD, READ_DATA: begin
          if (rx_cnt_q != RX_DONE) begin
            rx_shift_d = {rx_shift_q[RX_WIDTH-3:0], MOSI};
            rx_cnt_d   = rx_cnt_q + RCW'(1);
            if (rx_cnt_q == RX_LAST) begin
              rx_data_d  = {rx_shift_q, MOSI};
              rx_valid_d = 1'b1;
              if (state_q == READ_ADD) begin
                rd_addr_seen_d = 1'b1;
              end
              if (state_q == READ_DATA) begin
                rd_addr_seen_d = 1'b0;
                tx_wait_d      = 1'b1;
              end
            end
          end

          // Readout only runs after a completed READ_DATA frame.
          if (tx_wait_q && tx_valid) begin
            tx_shift_d = tx_data;
            tx_cnt_d   = TX_FULL;
            tx_wait_d  = 1'b0;
          end else if (tx_cnt_q != '0) begin
            miso_d     = tx_shift_q[TX_WIDTH-1];
            tx_shift_d = {tx_shift_q[TX_WIDTH-2:0], 1'b0};
            tx_cnt_d   = tx_cnt_q - TCW'(1);
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // All state in one register bank with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rx_cnt_q       <= '0;
      rx_shift_q     <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      tx_wait_q      <= 1'b0;
      tx_shift_q     <= '0;
      tx_cnt_q       <= '0;
      miso_q         <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      frame_err_q    <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_shift_q     <= rx_shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      tx_wait_q      <= tx_wait_d;
      tx_shift_q     <= tx_shift_d;
      tx_cnt_q       <= tx_cnt_d;
      miso_q         <= miso_d;
`ifdef SPI_FRAME_ERR_EN
      frame_err_q    <= frame_err_d;
`endif
    end
  end

  assign MISO      = miso_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign state_dbg = state_q;
`ifdef SPI_FRAME_ERR_EN
  assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if. Directed frames push their expected rx words
// and MISO bits into queues. Independent monitors compare them whenever
// the DUT presents rx_valid or a MISO readout.
module tb_spi_slave_if;

  localparam int RXW = 10;
  localparam int TXW = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_RADD  = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           ss_n;
  logic           mosi;
  logic           miso;
  logic [RXW-1:0] rx_data;
  logic           rx_valid;
  logic [TXW-1:0] tx_data;
  logic           tx_valid;
  logic           ram_tx_valid;
  logic           stim_tx_valid;
  logic [2:0]     state_dbg;
`ifdef SPI_FRAME_ERR_EN
  logic           frame_err;
`endif

  assign tx_valid = ram_tx_valid | stim_tx_valid;

  // Clock and DUT
  always #5 clk = ~clk;

  spi_slave_if #(.RX_WIDTH(RXW), .TX_WIDTH(TXW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SS_n      (ss_n),
    .MOSI      (mosi),
    .MISO      (miso),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .state_dbg (state_dbg)
`ifdef SPI_FRAME_ERR_EN
    ,
    .frame_err (frame_err)
`endif
  );

  // Scoreboard state
  int             n_checks = 0;
  int             n_pass = 0;
  logic [RXW-1:0] exp_q[$];
  logic           exp_miso_q[$];
  logic           started = 1'b0;
  int             miso_left = 0;
  logic           prev_rx_valid = 1'b0;
  int             frame_err_seen = 0;
  int             exp_frame_err = 0;
  logic           prev_frame_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: rx words, single-cycle rx_valid, MISO readout and MISO idle level.
  always @(posedge clk) begin
    #1;
    if (started) begin
      if (rx_valid) begin
        if (exp_q.size() == 0) begin
          chk("rx_valid_unexpected", 32'(rx_valid), 32'd0);
        end else begin
          chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
        chk("rx_valid_single", 32'(prev_rx_valid), 32'd0);
      end
      prev_rx_valid = rx_valid;

      if (miso_left > 0) begin
        chk("miso_bit", 32'(miso), 32'(exp_miso_q.pop_front()));
        miso_left--;
      end else begin
        chk("miso_idle", 32'(miso), 32'd0);
      end
      if (tx_valid && (miso_left == 0) && (exp_miso_q.size() != 0)) begin
        miso_left = TXW;
      end

`ifdef SPI_FRAME_ERR_EN
      if (frame_err) begin
        frame_err_seen++;
        chk("frame_err_single", 32'(prev_frame_err), 32'd0);
      end
      prev_frame_err = frame_err;
`endif
    end
  end

  // RAM model: a read-data opcode frame triggers one tx_valid with fixed data.
  always @(posedge clk) begin
    #1;
    if (started && rx_valid && (rx_data[RXW-1:RXW-2] == 2'b11)) begin
      @(negedge clk);
      tx_data      = 8'h3C;
      ram_tx_valid = 1'b1;
      @(negedge clk);
      ram_tx_valid = 1'b0;
    end
  end

  // Driver tasks
  task automatic send_bits(input logic [RXW-1:0] w, input int nbits);
    @(negedge clk);
    ss_n = 1'b0;
    mosi = 1'($urandom_range(0, 1));
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      mosi = w[RXW-1-i];
    end
  endtask

  task automatic end_txn();
    @(negedge clk);
    ss_n = 1'b1;
    mosi = 1'b0;
  endtask

  task automatic push_miso(input logic [TXW-1:0] b);
    logic [TXW-1:0] v;
    v = b;
    for (int i = TXW - 1; i >= 0; i--) begin
      exp_miso_q.push_back(v[i]);
    end
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    rst_n         = 1'b0;
    ss_n          = 1'b0;
    mosi          = 1'b0;
    stim_tx_valid = 1'b0;
    ram_tx_valid  = 1'b0;
    tx_data       = '0;

    // Reset held for two clocks with the slave selected and random MOSI.
    repeat (2) begin
      @(negedge clk);
      mosi = 1'($urandom_range(0, 1));
    end
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'h000);
    chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
    rst_n   = 1'b1;
    ss_n    = 1'b1;
    started = 1'b1;
    @(negedge clk);

    // Write address frame.
    exp_q.push_back(10'h0A5);
    send_bits(10'b00_1010_0101, RXW);
    @(negedge clk);
    chk("wr_addr_state", 32'(state_dbg), 32'(S_WRITE));
    end_txn();
    @(negedge clk);
    chk("wr_addr_idle", 32'(state_dbg), 32'(S_IDLE));

    // Write data frame, then a stray tx_valid that must be ignored.
    exp_q.push_back(10'h13C);
    send_bits(10'b01_0011_1100, RXW);
    @(negedge clk);
    chk("wr_data_state", 32'(state_dbg), 32'(S_WRITE));
    @(negedge clk);
    stim_tx_valid = 1'b1;
    @(negedge clk);
    stim_tx_valid = 1'b0;
    repeat (2) @(negedge clk);
    end_txn();

    // Read address frame, started after a single deselected cycle.
    exp_q.push_back(10'h2A5);
    send_bits(10'b10_1010_0101, RXW);
    @(negedge clk);
    chk("rd_addr_state", 32'(state_dbg), 32'(S_RADD));
    end_txn();

    // Read data frame: RAM returns 8'h3C, which appears on MISO as 0,0,1,1,1,1,0,0.
    exp_q.push_back(10'h300);
    push_miso(8'h3C);
    send_bits(10'b11_0000_0000, RXW);
    @(negedge clk);
    chk("rd_data_state", 32'(state_dbg), 32'(S_RDATA));
    repeat (12) @(negedge clk);
    end_txn();

    // rd_addr_seen is now clear, so an opcode-1 frame is a read address.
    exp_q.push_back(10'h301);
    send_bits(10'b11_0000_0001, RXW);
    @(negedge clk);
    chk("rd_no_addr_state", 32'(state_dbg), 32'(S_RADD));
    end_txn();

    // Abort after 5 of 10 bits.
    send_bits(10'b00_1111_0000, 5);
    end_txn();
    exp_frame_err++;
    @(negedge clk);
    chk("abort_idle", 32'(state_dbg), 32'(S_IDLE));
    chk("abort_rx_data_held", 32'(rx_data), 32'h301);

    // A full write frame after the abort decodes normally.
    exp_q.push_back(10'h055);
    send_bits(10'b00_0101_0101, RXW);
    @(negedge clk);
    chk("recover_state", 32'(state_dbg), 32'(S_WRITE));
    end_txn();

    // The abort left rd_addr_seen set, so this frame is a read data frame.
    exp_q.push_back(10'h3C5);
    push_miso(8'h3C);
    send_bits(10'b11_1100_0101, RXW);
    @(negedge clk);
    chk("rd_data2_state", 32'(state_dbg), 32'(S_RDATA));
    repeat (12) @(negedge clk);
    end_txn();
    @(negedge clk);
    chk("final_idle", 32'(state_dbg), 32'(S_IDLE));

    repeat (4) @(negedge clk);
    chk("rx_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("miso_queue_empty", 32'(exp_miso_q.size()), 32'd0);
`ifdef SPI_FRAME_ERR_EN
    chk("frame_err_count", 32'(frame_err_seen), 32'(exp_frame_err));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- SPI slave front end that sits directly upstream of the single-port RAM.
- Deserialises MOSI frames into 10-bit words (rx_data, rx_valid) that drive the RAM's din/rx_valid.
- Captures the RAM's 8-bit read data (tx_data, tx_valid) and serialises it on MISO, MSB first.
- SPI bit clock equals clk; one bit is transferred per clk while SS_n is low.

Parameters:
- RX_WIDTH, 10, frame payload width; [RX_WIDTH-1:RX_WIDTH-2] is the RAM opcode.
- TX_WIDTH, 8, read-data width shifted out on MISO.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- SS_n  input  1  slave select, active low; frames a transaction.
- MOSI  input  1  serial data in, MSB first.
- MISO  output  1  serial data out, MSB first.
- rx_data  output  RX_WIDTH  assembled frame to RAM din.
- rx_valid  output  1  one-cycle strobe, rx_data valid.
- tx_data  input  TX_WIDTH  read data from RAM dout.
- tx_valid  input  1  RAM read-data strobe.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, MISO=0, rx_data=0, rx_valid=0.
  - Bit counter=0, rd_addr_seen=0, tx shift register=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE -> CHK_CMD when SS_n=0 is sampled.
- CHK_CMD: sample MOSI as rx bit RX_WIDTH-1.
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_seen=0 -> READ_ADD.
  - MOSI=1 and rd_addr_seen=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA: shift the remaining RX_WIDTH-1 MOSI bits, one per clk, MSB first.
- After the last bit is sampled:
  - rx_data updates and rx_valid=1 on the next cycle, for exactly one cycle.
  - rx_data then holds until the next completed frame.
- READ_ADD frame completion sets rd_addr_seen=1.
- READ_DATA frame completion clears rd_addr_seen to 0.
- READ_DATA, after rx_valid: wait for tx_valid=1.
  - On that edge, latch tx_data into the shift register.
  - On the following TX_WIDTH cycles, MISO = bit TX_WIDTH-1 down to bit 0.
  - Afterwards MISO=0.
  - tx_valid arriving while not waiting is ignored.
- Any state, SS_n=1 sampled -> IDLE next cycle.
  - Partial frame is discarded: no rx_valid, and rd_addr_seen is unchanged.
  - MISO=0 and the counter is cleared.
- After a completed frame, remain in the current state with no further shifting until SS_n=1.
- MISO is 0 whenever not actively shifting.
- Back-to-back transactions: SS_n high for a single cycle is sufficient to return to IDLE.
- Reset mid-frame or mid-readout: immediate return to reset values on that edge.

Optional Feature:
- Macro: SPI_FRAME_ERR_EN.
- Defined:
  - Adds output port frame_err (1 bit, reset 0).
  - frame_err pulses 1 for one cycle when SS_n rises before rx_valid in CHK_CMD/WRITE/READ_ADD/READ_DATA.
  - frame_err also pulses if SS_n rises in READ_DATA before all TX_WIDTH bits are shifted out.
- Undefined: no frame_err port; aborts are silent.

Test Plan:
- Reset: hold rst_n=0 for 2 clks with SS_n=0 and random MOSI -> MISO=0, rx_valid=0, rx_data=10'h000.
- Write address: SS_n=0, shift 10'b00_1010_0101 -> one rx_valid pulse with rx_data=10'h0A5, state WRITE, then SS_n=1 -> IDLE.
- Write data: shift 10'b01_0011_1100 -> rx_data=10'h13C, rx_valid for exactly one cycle.
- Read sequence:
  - Read address 10'b10_1010_0101 -> rx_data=10'h2A5, rd_addr_seen=1.
  - Next frame 10'b11_0000_0000 -> rx_data=10'h300; model RAM returns tx_valid with tx_data=8'h3C.
  - MISO then emits 0,0,1,1,1,1,0,0 on consecutive clks; rd_addr_seen=0.
- Abort: SS_n=1 after 5 of 10 bits -> no rx_valid, rx_data unchanged.
  - Next full write frame decodes correctly.
  - With SPI_FRAME_ERR_EN defined, frame_err pulses once.
- Read-data without prior read-address: rd_addr_seen=0, frame starting with bit 1 -> enters READ_ADD (not READ_DATA).
